// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and small types for the frame reader.
package vga_pkg;

  // Horizontal timing in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;

  // Vertical timing in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  // Derived totals and sync windows (start inclusive, end exclusive)
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam int FRAME_PIXELS = 307200;
  localparam int PIX_W        = 12;
  localparam int ADDR_W       = 19;

  typedef logic [PIX_W-1:0] pixel_t;

  // Control bits that travel down the read-latency pipeline alongside the RAM data.
  // hs/vs here mean "sync window active", independent of pin polarity.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vid_ctl_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running horizontal/vertical counters with active-region, sync-window and
// frame-start decode. All decodes are aligned to the current counter position.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic clk_r,
  input  logic rst_n,
  output logic de_c,
  output logic hs_c,
  output logic vs_c,
  output logic last_pos,
  output logic frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_S    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_S    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E    = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // Pixel counter wraps every line; line counter advances on each pixel wrap.
  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign de_c     = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
  assign hs_c     = (h_cnt >= HS_S) && (h_cnt < HS_E);
  assign vs_c     = (v_cnt >= VS_S) && (v_cnt < VS_E);
  assign last_pos = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Gated with rst_n so the pulse stays low while the counters sit at (0,0) in reset.
  assign frame_start = rst_n && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_frame_reader.sv
// VGA read-side consumer of the frame RAM: sequential address pointer, control
// pipeline matched to the RAM read latency, and the registered RGB/sync pins.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_pkg::H_FP,
  parameter int   H_SYNC   = vga_pkg::H_SYNC,
  parameter int   H_BP     = vga_pkg::H_BP,
  parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_pkg::V_FP,
  parameter int   V_SYNC   = vga_pkg::V_SYNC,
  parameter int   V_BP     = vga_pkg::V_BP,
  parameter int   RD_LAT   = 1,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic              clk_r,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] addr_r,
  input  logic [PIX_W-1:0]  dat_r,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start
);

  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIX - 1);

  logic de_c;
  logic hs_c;
  logic vs_c;
  logic last_pos;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk_r       (clk_r),
    .rst_n       (rst_n),
    .de_c        (de_c),
    .hs_c        (hs_c),
    .vs_c        (vs_c),
    .last_pos    (last_pos),
    .frame_start (frame_start)
  );

  // Address tracks v*H_ACTIVE+h by counting active pixels; it saturates on the
  // last pixel of the frame and is cleared on the final blanking cycle.
  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= '0;
    end else if (last_pos) begin
      addr_r <= '0;
    end else if (de_c && (addr_r != ADDR_LAST)) begin
      addr_r <= addr_r + 1'b1;
    end
  end

  vid_ctl_t ctl_d [RD_LAT];
  vid_ctl_t ctl_o;

  // Delay de/hs/vs by the RAM read latency so they line up with dat_r.
  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) ctl_d[i] <= '0;
    end else begin
      ctl_d[0] <= '{de: de_c, hs: hs_c, vs: vs_c};
      for (int i = 1; i < RD_LAT; i++) ctl_d[i] <= ctl_d[i-1];
    end
  end

  assign ctl_o = ctl_d[RD_LAT-1];

  // Output register: applies sync polarity and blanks RGB outside active video or when disabled.
  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      vga_hs <= ctl_o.hs ? SYNC_POL : ~SYNC_POL;
      vga_vs <= ctl_o.vs ? SYNC_POL : ~SYNC_POL;
      if (ctl_o.de && en) begin
        {vga_r, vga_g, vga_b} <= dat_r;
      end else begin
        {vga_r, vga_g, vga_b} <= '0;
      end
    end
  end

endmodule
